// File: rtl/aes_rotate_pipe.sv
// Elastic multi-lane byte-rotate pipeline with a wrapping round tag.
// Rotation happens ahead of stage 1; later stages only carry data, tag and valid.
module aes_rotate_pipe #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ROUNDS = 10,
  localparam int unsigned ROT_W = (WORD_W > 8) ? $clog2(WORD_W / 8) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*WORD_W-1:0]   in_words,
  input  logic [ROT_W-1:0]          in_rot,
  input  logic                      in_dir,
  input  logic [LANES-1:0]          in_disable,
  input  logic                      in_restart,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   out_words,
  output logic [3:0]                out_round
);

  localparam int unsigned NB    = WORD_W / 8;
  localparam int unsigned DW    = LANES * WORD_W;
  localparam int unsigned TAG_W = $clog2(ROUNDS);

  logic [DW-1:0]    rot_c;
  logic [DEPTH-1:0] load_c;
  logic             accept_c;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [TAG_W-1:0] tag_d  [DEPTH];
  logic [TAG_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;

  // Output byte j of a rotated lane takes input byte (j - k) for left, (j + k) for right.
  always_comb begin
    int unsigned k;
    int unsigned src;
    rot_c = in_words;
    k     = 32'(in_rot);
    src   = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!in_disable[l]) begin
        for (int unsigned j = 0; j < NB; j++) begin
          src = in_dir ? ((j + k) % NB) : ((j + NB - k) % NB);
          rot_c[l*WORD_W + j*8 +: 8] = in_words[l*WORD_W + src*8 +: 8];
        end
      end
    end
  end

  // Stall chain: a stage loads when empty or when the stage after it loads.
  always_comb begin
    logic ld_next;
    load_c  = '0;
    ld_next = out_ready;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      ld_next   = ~valid_q[s] | ld_next;
      load_c[s] = ld_next;
    end
  end

  assign in_ready = load_c[0] & rdy_q;
  assign accept_c = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b1;
    for (int s = 0; s < DEPTH; s++) begin
      data_d[s] = data_q[s];
      tag_d[s]  = tag_q[s];
    end
    if (load_c[0]) begin
      valid_d[0] = accept_c;
      data_d[0]  = rot_c;
      tag_d[0]   = in_restart ? '0 : cnt_q;
    end
    for (int s = 1; s < DEPTH; s++) begin
      if (load_c[s]) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
        tag_d[s]   = tag_q[s-1];
      end
    end
    if (accept_c) begin
      if (in_restart)
        cnt_d = TAG_W'(1);
      else if (cnt_q == TAG_W'(ROUNDS - 1))
        cnt_d = '0;
      else
        cnt_d = cnt_q + TAG_W'(1);
    end
  end

  // rdy_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      data_q[s] <= data_d[s];
      tag_q[s]  <= tag_d[s];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_words = data_q[DEPTH-1];
  assign out_round = 4'(tag_q[DEPTH-1]);

endmodule

// File: doc/aes_rotate_pipe.md
AES_ROTATE_PIPE -- requirements
Module: aes_rotate_pipe

Interface
REQ-001 Parameter: WORD_W, 32, word width in bits; multiple of 8; WORD_W/8 a power of two.
REQ-002 Parameter: LANES, 4, independent words processed per transfer.
REQ-003 Parameter: DEPTH, 2, pipeline register stages (1..4).
REQ-004 Parameter: ROUNDS, 10, round-tag modulus (2..16).
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: in_valid  input  1  input transfer offered.
REQ-008 Port: in_ready  output  1  block can accept the offered transfer.
REQ-009 Port: in_words  input  LANES*WORD_W  lane i at bits [i*WORD_W +: WORD_W].
REQ-010 Port: in_rot  input  log2(WORD_W/8)  rotation amount in bytes, shared by all lanes.
REQ-011 Port: in_dir  input  1  0 = rotate left (toward MSB), 1 = rotate right.
REQ-012 Port: in_disable  input  LANES  per-lane bypass; 1 = lane passes unrotated.
REQ-013 Port: in_restart  input  1  forces this transfer's round tag to 0.
REQ-014 Port: out_valid  output  1  output transfer available.
REQ-015 Port: out_ready  input  1  downstream accepts output.
REQ-016 Port: out_words  output  LANES*WORD_W  rotated words, same lane packing.
REQ-017 Port: out_round  output  4  round tag of the output transfer.

Function
REQ-018 Transfer accepted at in_valid && in_ready; delivered at out_valid && out_ready.
REQ-019 Left rotate by k: out = {in[WORD_W-1-8k:0], in[WORD_W-1:WORD_W-8k]}; k=0 identity; right rotate by k is the exact inverse.
REQ-020 WORD_W=32, k=1, dir=0 equals AES RotWord (0x09cf4f3c -> 0xcf4f3c09).
REQ-021 Lane with in_disable[i]=1 outputs in_words lane i unchanged regardless of in_rot/in_dir.
REQ-022 Rotation is computed combinationally ahead of stage 1; stages 2..DEPTH carry data, tag, valid only.
REQ-023 Elastic pipeline: stage s loads when it is empty or its contents advance the same cycle; last stage advances on out_ready.
REQ-024 in_ready = stage-1 empty OR stage 1 advancing this cycle; combinational from out_ready through the stall chain, no combinational path from in_valid to in_ready.
REQ-025 Latency exactly DEPTH cycles from acceptance to out_valid when no backpressure; sustained throughput one transfer per cycle.
REQ-026 While out_valid=1 and out_ready=0, out_words and out_round hold stable; no transfer dropped or duplicated; order preserved.
REQ-027 Round counter: on each acceptance the transfer is tagged with current count; count then increments, wrapping ROUNDS-1 -> 0.
REQ-028 in_restart=1 on an accepted transfer: tag = 0, count becomes 1; in_restart without acceptance has no effect.
REQ-029 Pipeline fully occupied (DEPTH transfers) with out_ready=0: in_ready=0; an offered input is neither accepted nor counted.
REQ-030 Full pipeline, out_ready=1 and in_valid=1 same cycle: one delivery and one acceptance, occupancy unchanged.
REQ-031 out_round upper bits beyond log2(ROUNDS) are zero.

Reset
REQ-032 reset asserted: all stage valid bits 0, out_valid=0, round count 0, immediately (asynchronous).
REQ-033 While reset=1: in_ready=0; data/tag registers need no reset value, out_words is don't-care while out_valid=0.
REQ-034 Reset mid-operation discards all in-flight transfers; first transfer after deassertion is tagged 0.
REQ-035 in_ready may rise no earlier than the first rising edge after reset deassertion.

Verification
REQ-036 Defaults, lane0=0x09cf4f3c, rot=1, dir=0, disable=0 -> after 2 cycles lane0=0xcf4f3c09, out_round=0.
REQ-037 Same words, rot=3, dir=1, disable=4'b0010 -> lane0=0xcf4f3c09, lane1 unchanged; left-then-right by 2 on 0x11223344 returns 0x11223344.
REQ-038 12 back-to-back transfers, out_ready=1 -> one output per cycle, tags 0..9,0,1.
REQ-039 out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 accepted, in_ready=0 thereafter, outputs held stable; release -> all delivered in order.
REQ-040 in_restart on 4th transfer -> tags 0,1,2,0,1.
REQ-041 reset pulse with 2 in flight -> out_valid=0 same cycle; subsequent transfer tagged 0, no stale output.
